// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, functs,
// state codes, datapath select encodings and the instruction-class table.
package mc_pkg;

  // Register written by jal; steered by the datapath when RegDst selects $31
  localparam logic [4:0] RA_REG = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] EOP_SIGN     = 2'b00;
  localparam logic [1:0] EOP_ZERO     = 2'b01;
  localparam logic [1:0] EOP_LUI      = 2'b10;
  localparam logic [1:0] EOP_SIGN_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_EXT  = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] NPC_ALU    = 2'b00;
  localparam logic [1:0] NPC_ALUOUT = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  // One-hot instruction classes; an all-zero vector means unsupported
  localparam int CLS_ADDU = 0;
  localparam int CLS_SUBU = 1;
  localparam int CLS_ORI  = 2;
  localparam int CLS_LUI  = 3;
  localparam int CLS_LW   = 4;
  localparam int CLS_SW   = 5;
  localparam int CLS_BEQ  = 6;
  localparam int CLS_J    = 7;
  localparam int CLS_JAL  = 8;
  localparam int CLS_NOP  = 9;
  localparam int CLS_N    = 10;

  typedef logic [CLS_N-1:0] cls_t;

  function automatic logic [5:0] cls_op(input int idx);
    case (idx)
      CLS_ORI: return OP_ORI;
      CLS_LUI: return OP_LUI;
      CLS_LW:  return OP_LW;
      CLS_SW:  return OP_SW;
      CLS_BEQ: return OP_BEQ;
      CLS_J:   return OP_J;
      CLS_JAL: return OP_JAL;
      default: return OP_RTYPE;
    endcase
  endfunction

  function automatic logic cls_has_funct(input int idx);
    return (idx == CLS_ADDU) || (idx == CLS_SUBU) || (idx == CLS_NOP);
  endfunction

  function automatic logic [5:0] cls_funct(input int idx);
    case (idx)
      CLS_ADDU: return FN_ADDU;
      CLS_SUBU: return FN_SUBU;
      default:  return FN_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and its datapath:
// instruction fields and ALU flag in, enables and selects out.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [1:0] EOp;
  logic       PCWr;
  logic       IRWr;
  logic       RegWr;
  logic       MemWr;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] NPCSel;
  logic [2:0] state;
  logic       retire;
  logic       illegal;

  modport slave (
    input  op, funct, zero,
    output EOp, PCWr, IRWr, RegWr, MemWr, RegDst, WDSel,
           ALUSrcA, ALUSrcB, ALUOp, NPCSel, state, retire, illegal
  );

  modport master (
    output op, funct, zero,
    input  EOp, PCWr, IRWr, RegWr, MemWr, RegDst, WDSel,
           ALUSrcA, ALUSrcB, ALUOp, NPCSel, state, retire, illegal
  );
endinterface

// File: rtl/mc_decode.sv
// Instruction classifier: op/funct to a one-hot class vector, with illegal
// raised when no supported class matches.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       illegal
);

  generate
    for (genvar gi = 0; gi < CLS_N; gi++) begin : g_cls
      // funct only qualifies the R-type encodings (addu, subu, nop)
      assign cls[gi] = (op == cls_op(gi)) &&
                       (!cls_has_funct(gi) || (funct == cls_funct(gi)));
    end
  endgenerate

  assign illegal = ~|cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register plus combinational decode of
// datapath enables/selects from state, op, funct and the ALU zero flag.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mc_ctrl_if.slave   bus
);

  state_t     state_reg;
  state_t     state_next;
  cls_t       cls;
  logic       dec_illegal;
  logic       is_rtype;

  logic       pcwr;
  logic       irwr;
  logic       regwr;
  logic       memwr;
  logic [1:0] eop;
  logic [1:0] regdst;
  logic [1:0] wdsel;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] npcsel;
  logic       retire;
  logic       illegal;

  mc_decode u_decode (
    .op      (bus.op),
    .funct   (bus.funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  assign is_rtype = cls[CLS_ADDU] | cls[CLS_SUBU];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    pcwr       = 1'b0;
    irwr       = 1'b0;
    regwr      = 1'b0;
    memwr      = 1'b0;
    eop        = EOP_SIGN;
    regdst     = DST_RT;
    wdsel      = WD_ALUOUT;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    aluop      = ALU_ADD;
    npcsel     = NPC_ALU;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      S_FETCH: begin
        irwr       = 1'b1;
        pcwr       = 1'b1;
        alusrcb    = SRCB_FOUR;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        // Branch target PC+4+(imm<<2) is computed here speculatively into ALUOut
        alusrcb = SRCB_EXT;
        eop     = EOP_SIGN_SH2;
        if (cls[CLS_J] || cls[CLS_JAL]) begin
          pcwr   = 1'b1;
          npcsel = NPC_JUMP;
          retire = 1'b1;
        end
        if (cls[CLS_JAL]) begin
          // GRF captures the pre-jump PC (already PC+4) on the same edge
          regwr  = 1'b1;
          regdst = DST_RA;
          wdsel  = WD_PC;
        end
        if (cls[CLS_NOP] || dec_illegal) begin
          retire = 1'b1;
        end
        illegal = dec_illegal;
        if (!(cls[CLS_J] || cls[CLS_JAL] || cls[CLS_NOP] || dec_illegal)) begin
          state_next = S_EXE;
        end
      end

      S_EXE: begin
        alusrca = 1'b1;
        if (is_rtype) begin
          alusrcb    = SRCB_RT;
          aluop      = cls[CLS_SUBU] ? ALU_SUB : ALU_ADD;
          state_next = S_WB;
        end else if (cls[CLS_ORI]) begin
          alusrcb    = SRCB_EXT;
          eop        = EOP_ZERO;
          aluop      = ALU_OR;
          state_next = S_WB;
        end else if (cls[CLS_LUI]) begin
          // rs is $0 for lui, so rs + (imm<<16) yields the upper immediate
          alusrcb    = SRCB_EXT;
          eop        = EOP_LUI;
          state_next = S_WB;
        end else if (cls[CLS_LW] || cls[CLS_SW]) begin
          alusrcb    = SRCB_EXT;
          eop        = EOP_SIGN;
          state_next = S_MEM;
        end else if (cls[CLS_BEQ]) begin
          alusrcb = SRCB_RT;
          aluop   = ALU_SUB;
          pcwr    = bus.zero;
          npcsel  = NPC_ALUOUT;
          retire  = 1'b1;
        end
      end

      S_MEM: begin
        if (cls[CLS_SW]) begin
          memwr  = 1'b1;
          retire = 1'b1;
        end else if (cls[CLS_LW]) begin
          state_next = S_WB;
        end
      end

      S_WB: begin
        regwr  = 1'b1;
        retire = 1'b1;
        regdst = is_rtype ? DST_RD : DST_RT;
        wdsel  = cls[CLS_LW] ? WD_MDR : WD_ALUOUT;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Architectural writes are suppressed for the whole time reset is held
  assign bus.PCWr    = pcwr & ~reset;
  assign bus.IRWr    = irwr & ~reset;
  assign bus.RegWr   = regwr & ~reset;
  assign bus.MemWr   = memwr & ~reset;
  assign bus.retire  = retire & ~reset;
  assign bus.illegal = illegal & ~reset;

  assign bus.EOp     = eop;
  assign bus.RegDst  = regdst;
  assign bus.WDSel   = wdsel;
  assign bus.ALUSrcA = alusrca;
  assign bus.ALUSrcB = alusrcb;
  assign bus.ALUOp   = aluop;
  assign bus.NPCSel  = npcsel;
  assign bus.state   = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction micro-program model,
// directed and random instruction streams, mid-instruction resets.
module tb_mc_ctrl;
  import mc_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] wr;    // {PCWr, IRWr, RegWr, MemWr}
    logic [1:0] eop;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aluop;
    logic [1:0] npc;
    logic       ret;
    logic       ill;
  } rec_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_NOP = 9, K_ILL = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mc_ctrl_if bus_if();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  logic [21:0] act;
  logic [21:0] exp_r = '0;
  logic [21:0] mask_r = '0;
  logic        chk_en = 1'b0;
  logic        last_retire = 1'b0;
  string       tag = "idle";
  int          n_pass = 0;
  int          n_total = 0;

  assign act = {bus_if.state, bus_if.PCWr, bus_if.IRWr, bus_if.RegWr, bus_if.MemWr,
                bus_if.EOp, bus_if.RegDst, bus_if.WDSel, bus_if.ALUSrcA,
                bus_if.ALUSrcB, bus_if.ALUOp, bus_if.NPCSel, bus_if.retire, bus_if.illegal};

  function automatic rec_t mk(input logic [2:0] st, input logic [3:0] wr,
                              input logic [1:0] eop, input logic [1:0] regdst,
                              input logic [1:0] wdsel, input logic asa,
                              input logic [1:0] asb, input logic [1:0] aluop,
                              input logic [1:0] npc, input logic ret, input logic ill);
    rec_t r;
    r = {st, wr, eop, regdst, wdsel, asa, asb, aluop, npc, ret, ill};
    return r;
  endfunction

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: begin
        if (f == 6'h21) return K_ADDU;
        if (f == 6'h23) return K_SUBU;
        if (f == 6'h00) return K_NOP;
        return K_ILL;
      end
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // Cycle-by-cycle datapath actions of each instruction, as a short program
  function automatic rec_t micro(input int kind, input int step, input logic z, output int len);
    rec_t prog [5];
    rec_t wb_imm;
    for (int i = 0; i < 5; i++) prog[i] = '0;
    prog[0] = mk(3'd0, 4'b1100, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    prog[1] = mk(3'd1, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    wb_imm  = mk(3'd4, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    len = 2;
    case (kind)
      K_ADDU, K_SUBU: begin
        prog[2] = mk(3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00,
                     (kind == K_SUBU) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0);
        prog[3] = mk(3'd4, 4'b0010, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        len = 4;
      end
      K_ORI: begin
        prog[2] = mk(3'd2, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
        prog[3] = wb_imm;
        len = 4;
      end
      K_LUI: begin
        prog[2] = mk(3'd2, 4'b0000, 2'b10, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        prog[3] = wb_imm;
        len = 4;
      end
      K_LW: begin
        prog[2] = mk(3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        prog[3] = mk(3'd3, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        prog[4] = mk(3'd4, 4'b0010, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        len = 5;
      end
      K_SW: begin
        prog[2] = mk(3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        prog[3] = mk(3'd3, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        len = 4;
      end
      K_BEQ: begin
        prog[2] = mk(3'd2, {z, 3'b000}, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
        len = 3;
      end
      K_J:   prog[1] = mk(3'd1, 4'b1000, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
      K_JAL: prog[1] = mk(3'd1, 4'b1010, 2'b11, 2'b10, 2'b10, 1'b0, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
      K_NOP: prog[1] = mk(3'd1, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
      default: prog[1] = mk(3'd1, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
    endcase
    if (step < 0 || step >= len) return '0;
    return prog[step];
  endfunction

  // Single compare point: every checked cycle, DUT outputs vs model
  always @(negedge clk) begin
    if (chk_en) begin
      n_total++;
      if ((act & mask_r) === (exp_r & mask_r)) begin
        n_pass++;
      end else begin
        $display("FAIL %s t=%0t outputs=%06h required=%06h mask=%06h",
                 tag, $time, act & mask_r, exp_r & mask_r, mask_r);
      end
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d required=%0d", name, got, want);
  endtask

  task automatic cyc(input logic [21:0] e, input logic [21:0] m);
    exp_r  = e;
    mask_r = m;
    chk_en = 1'b1;
    @(negedge clk);
    #1 last_retire = bus_if.retire;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] rst_mask(input logic with_state);
    rec_t m;
    m = mk(with_state ? 3'b111 : 3'b000, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0,
           2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    return m;
  endfunction

  // Hold reset for n cycles; the first cycle still shows the interrupted state
  task automatic reset_cycles(input int n, input logic [2:0] first_st);
    rec_t e;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tag = "reset";
      e = '0;
      e.st = (i == 0) ? first_st : 3'd0;
      cyc(e, rst_mask(1'b1));
    end
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int zmode,
                           input int abort_at, input int rst_len, input string nm,
                           output int cpi);
    int   kind;
    int   len;
    logic z;
    rec_t e;
    kind = kind_of(iop, ifn);
    e = micro(kind, 0, 1'b0, len);
    cpi = 0;
    for (int s = 0; s < len; s++) begin
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      bus_if.zero = z;
      if (s == 0) begin
        bus_if.op    = 6'($urandom_range(0, 63));
        bus_if.funct = 6'($urandom_range(0, 63));
      end else begin
        bus_if.op    = iop;
        bus_if.funct = ifn;
      end
      e = micro(kind, s, z, len);
      if (s == abort_at) begin
        reset_cycles(rst_len, e.st);
        return;
      end
      tag = nm;
      cyc(e, '1);
      if (last_retire && cpi == 0) cpi = s + 1;
    end
  endtask

  task automatic pick_instr(output logic [5:0] o, output logic [5:0] f);
    int r;
    r = $urandom_range(0, 10);
    f = 6'($urandom_range(0, 63));
    case (r)
      0: begin o = 6'h00; f = 6'h21; end
      1: begin o = 6'h00; f = 6'h23; end
      2: o = 6'h0D;
      3: o = 6'h0F;
      4: o = 6'h23;
      5: o = 6'h2B;
      6: o = 6'h04;
      7: o = 6'h02;
      8: o = 6'h03;
      9: begin o = 6'h00; f = 6'h00; end
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          o = 6'h00;
          if (f == 6'h00 || f == 6'h21 || f == 6'h23) f = 6'h20;
        end else begin
          o = 6'($urandom_range(0, 63));
          if (kind_of(o, 6'h00) != K_ILL) o = 6'h3F;
        end
      end
    endcase
  endtask

  initial begin
    int cpi;
    logic [5:0] o;
    logic [5:0] f;
    bus_if.op    = OP_LW;
    bus_if.funct = 6'h00;
    bus_if.zero  = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset_cycles(2, 3'd0);

    // lw interrupted by a 2-cycle reset while in EXE
    run_instr(6'h23, 6'h00, -1, 2, 2, "lw_reset_exe", cpi);

    run_instr(6'h0D, 6'h15, -1, -1, 0, "ori", cpi);
    check_int("ori_cpi", cpi, 4);
    run_instr(6'h23, 6'h07, -1, -1, 0, "lw", cpi);
    check_int("lw_cpi", cpi, 5);
    run_instr(6'h2B, 6'h01, -1, -1, 0, "sw", cpi);
    check_int("sw_cpi", cpi, 4);
    run_instr(6'h04, 6'h00, 1, -1, 0, "beq_taken", cpi);
    check_int("beq_taken_cpi", cpi, 3);
    run_instr(6'h04, 6'h00, 0, -1, 0, "beq_not_taken", cpi);
    check_int("beq_not_taken_cpi", cpi, 3);
    run_instr(6'h03, 6'h2A, -1, -1, 0, "jal", cpi);
    check_int("jal_cpi", cpi, 2);
    run_instr(6'h02, 6'h00, -1, -1, 0, "j", cpi);
    check_int("j_cpi", cpi, 2);
    run_instr(6'h3F, 6'h00, -1, -1, 0, "illegal_op", cpi);
    check_int("illegal_op_cpi", cpi, 2);
    run_instr(6'h00, 6'h20, -1, -1, 0, "illegal_funct", cpi);
    check_int("illegal_funct_cpi", cpi, 2);
    run_instr(6'h00, 6'h00, -1, -1, 0, "nop", cpi);
    check_int("nop_cpi", cpi, 2);
    run_instr(6'h00, 6'h21, -1, -1, 0, "addu", cpi);
    check_int("addu_cpi", cpi, 4);
    run_instr(6'h00, 6'h23, -1, -1, 0, "subu", cpi);
    check_int("subu_cpi", cpi, 4);
    run_instr(6'h0F, 6'h3C, -1, -1, 0, "lui", cpi);
    check_int("lui_cpi", cpi, 4);

    for (int n = 0; n < 400; n++) begin
      pick_instr(o, f);
      if ($urandom_range(0, 15) == 0)
        run_instr(o, f, -1, $urandom_range(1, 4), $urandom_range(1, 2), "rand_abort", cpi);
      else
        run_instr(o, f, -1, -1, 0, "rand", cpi);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control FSM; sequences the shared datapath (PC, IR, GRF, immediate extender, ALU, DM) over FETCH/DECODE/EXE/MEM/WB.
- Drives extender mode EOp each cycle: 00 sign, 01 zero, 10 lui (imm<<16), 11 sign<<2.
- Supported: addu, subu, ori, lui, lw, sw, beq, j, jal, nop; anything else retires as a no-op with illegal flagged.

Parameters:
- RA_REG, 5'd31, destination register index for jal (documentation only; selected via RegDst=10).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- EOp  out  2  extender mode
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- RegWr  out  1  GRF write enable
- MemWr  out  1  DM write enable
- RegDst  out  2  00 rt, 01 rd, 10 $31
- WDSel  out  2  00 ALUOut, 01 MDR, 10 PC
- ALUSrcA  out  1  0 PC, 1 rs
- ALUSrcB  out  2  00 rt, 01 constant 4, 10 ext
- ALUOp  out  2  00 add, 01 sub, 10 or
- NPCSel  out  2  00 ALU result, 01 ALUOut (branch target), 10 {PC[31:28], instr_index, 2'b00}
- state  out  3  current state (debug)
- retire  out  1  high on last cycle of each instruction
- illegal  out  1  high on DECODE cycle of an unsupported encoding

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- State register only; all outputs are combinational from state, op, funct and zero.
- Encodings: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5-7 go to FETCH with all enables 0.
- Reset: state<=FETCH at the clock edge. While reset=1, PCWr, IRWr, RegWr and MemWr are forced to 0, retire=0 and illegal=0 regardless of state. A reset asserted mid-instruction abandons that instruction with no further writes.
- Defaults in every state: all enables 0, all selects 00, EOp=00, retire=0, illegal=0.
- FETCH: IRWr=1, PCWr=1, ALUSrcA=0, ALUSrcB=01, ALUOp=add, NPCSel=00 -> DECODE.
- DECODE (PC already holds PC+4): ALUSrcA=0, ALUSrcB=10, EOp=11, ALUOp=add. ALUOut latches the branch target.
  - j: PCWr=1, NPCSel=10, retire=1 -> FETCH.
  - jal: additionally RegWr=1, RegDst=10, WDSel=10. The GRF samples the old PC+4 at the same edge the PC is rewritten.
  - nop (op=0, funct=0): retire=1 -> FETCH.
  - Unsupported op, or R-type funct other than addu(0x21)/subu(0x23): illegal=1, retire=1 -> FETCH.
  - Otherwise -> EXE.
- EXE:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp add/sub -> WB.
  - ori: ALUSrcA=1, ALUSrcB=10, EOp=01, ALUOp=or -> WB.
  - lui: ALUSrcA=1 (rs=$0), ALUSrcB=10, EOp=10, add -> WB.
  - lw/sw: ALUSrcA=1, ALUSrcB=10, EOp=00, add -> MEM.
  - beq: ALUSrcA=1, ALUSrcB=00, sub. PCWr=zero, NPCSel=01, retire=1 -> FETCH.
- MEM:
  - sw: MemWr=1, retire=1 -> FETCH.
  - lw: no enables; MDR captures -> WB.
- WB: RegWr=1, retire=1 -> FETCH.
  - R-type: RegDst=01, WDSel=00.
  - ori/lui: RegDst=00, WDSel=00.
  - lw: RegDst=00, WDSel=01.
- Cycles per instruction: j/jal/nop/illegal 2; beq 3; R/ori/lui/sw 4; lw 5.
- op/funct are sampled only in DECODE..WB; their value during FETCH is don't-care.

Decomposition:
- Package mc_pkg:
  - opcode constants: R=0x00, ori=0x0D, lui=0x0F, lw=0x23, sw=0x2B, beq=0x04, j=0x02, jal=0x03
  - funct constants: addu=0x21, subu=0x23
  - state encodings; EOp codes; ALUOp, ALUSrcB, RegDst, WDSel and NPCSel encodings
- Sub-module mc_decode: combinational op/funct -> one-hot instruction class plus illegal. Instantiated once inside mc_ctrl.

Test Plan:
- reset=1 for 2 cycles in EXE with op=lw -> state=0, all enables 0 during reset; first post-reset cycle has IRWr=PCWr=1.
- ori (op 0x0D) -> states 0,1,2,4. EXE has EOp=01, ALUOp=10. WB has RegWr=1, RegDst=00, WDSel=00, retire=1.
- lw (0x23) then sw (0x2B) -> 5 then 4 cycles. EOp=00 in EXE. WDSel=01 in WB for lw; MemWr=1 only in sw MEM.
- beq with zero=1, then zero=0 -> DECODE EOp=11; EXE PCWr=1 and NPCSel=01 only when zero=1; 3 cycles each.
- jal (0x03) -> DECODE: PCWr=1, NPCSel=10, RegWr=1, RegDst=10, WDSel=10, retire=1; next state FETCH.
- op=0x3F, then op=0 with funct=0x20 -> illegal=1 and retire=1 in DECODE, no enables asserted; nop (funct=0) has illegal=0.
